// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program counter and run control with branch-target LUT and cycle counter
module fetch_sequencer #(
  parameter int D = 12,
  parameter int A = 3,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          halt,
  input  logic          br_en,
  input  logic [A-1:0]  br_idx,
  input  logic          lut_we,
  input  logic [A-1:0]  lut_waddr,
  input  logic [D-1:0]  lut_wdata,
  output logic [D-1:0]  prog_ctr,
  output logic          running,
  output logic          done,
  output logic [CW-1:0] cycle_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [D-1:0] lut [2**A];
  logic start;
  assign start = req && state != RUN;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      prog_ctr <= '0;
      running <= 1'b0;
      done <= 1'b0;
      cycle_cnt <= '0;
      for (int i = 0; i < 2**A; i++) lut[i] <= '0;
    end else begin
      if (lut_we) lut[lut_waddr] <= lut_wdata;
      if (start) begin
        state <= RUN;
        prog_ctr <= '0;
        running <= 1'b1;
        done <= 1'b0;
        cycle_cnt <= '0;
      end else if (state == RUN) begin
        cycle_cnt <= &cycle_cnt ? cycle_cnt : cycle_cnt + CW'(1);
        if (halt) begin
          state <= DONE;
          running <= 1'b0;
          done <= 1'b1;
        end else begin
          // the branch reads the pre-edge LUT contents, so a same-cycle write is not seen
          prog_ctr <= br_en ? lut[br_idx] : prog_ctr + D'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: vector table with an expected-output queue, plus counter saturation sequence
module tb_fetch_sequencer;
  logic clk = 0;
  logic reset = 0, req = 0, halt = 0, br_en = 0, lut_we = 0;
  logic [2:0] br_idx = 0, lut_waddr = 0;
  logic [11:0] lut_wdata = 0;
  logic [11:0] prog_ctr;
  logic running, done;
  logic [15:0] cycle_cnt;
  int tests = 0, fails = 0;

  fetch_sequencer dut (
    .clk(clk), .reset(reset), .req(req), .halt(halt), .br_en(br_en), .br_idx(br_idx),
    .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .prog_ctr(prog_ctr), .running(running), .done(done), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rs, rq, h, b;
    logic [2:0] bi;
    logic we;
    logic [2:0] wa;
    logic [11:0] wd;
    logic [11:0] pc;
    logic r, d;
    logic [15:0] c;
  } vec_t;
  typedef struct {
    logic [11:0] pc;
    logic r, d;
    logic [15:0] c;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic void add(logic rs, logic rq, logic h, logic b, logic [2:0] bi,
                              logic we, logic [2:0] wa, logic [11:0] wd,
                              logic [11:0] pc, logic r, logic d, logic [15:0] c);
    vec_t v;
    v.rs = rs; v.rq = rq; v.h = h; v.b = b; v.bi = bi;
    v.we = we; v.wa = wa; v.wd = wd; v.pc = pc; v.r = r; v.d = d; v.c = c;
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    // rs rq h b bi we wa wd -> pc r d cnt
    add(1,0,0,0,0, 0,0,12'h000, 12'h000,0,0,0);
    add(0,0,1,1,3, 1,3,12'h0A0, 12'h000,0,0,0);
    add(0,0,0,0,0, 1,1,12'h010, 12'h000,0,0,0);
    add(0,0,0,0,0, 1,7,12'hFFF, 12'h000,0,0,0);
    add(0,0,0,0,0, 1,2,12'h007, 12'h000,0,0,0);
    add(0,0,0,0,0, 1,4,12'h020, 12'h000,0,0,0);
    add(0,1,0,0,0, 0,0,12'h000, 12'h000,1,0,0);
    add(0,0,0,0,0, 0,0,12'h000, 12'h001,1,0,1);
    add(0,0,0,0,0, 0,0,12'h000, 12'h002,1,0,2);
    add(0,0,0,1,3, 0,0,12'h000, 12'h0A0,1,0,3);
    add(0,0,0,0,0, 0,0,12'h000, 12'h0A1,1,0,4);
    add(0,1,0,0,0, 0,0,12'h000, 12'h0A2,1,0,5);
    add(0,0,0,1,7, 0,0,12'h000, 12'hFFF,1,0,6);
    add(0,0,0,0,0, 0,0,12'h000, 12'h000,1,0,7);
    add(0,0,0,1,1, 1,1,12'h055, 12'h010,1,0,8);
    add(0,0,0,1,1, 0,0,12'h000, 12'h055,1,0,9);
    add(0,0,0,1,2, 0,0,12'h000, 12'h007,1,0,10);
    add(0,0,1,1,3, 0,0,12'h000, 12'h007,0,1,11);
    add(0,0,1,1,3, 0,0,12'h000, 12'h007,0,1,11);
    add(0,1,0,0,0, 0,0,12'h000, 12'h000,1,0,0);
    add(0,0,0,0,0, 0,0,12'h000, 12'h001,1,0,1);
    add(0,0,0,1,4, 0,0,12'h000, 12'h020,1,0,2);
    add(1,1,0,1,3, 1,3,12'h123, 12'h000,0,0,0);
    add(0,1,0,0,0, 0,0,12'h000, 12'h000,1,0,0);
    add(0,0,0,1,3, 0,0,12'h000, 12'h000,1,0,1);
    add(0,0,0,1,4, 0,0,12'h000, 12'h000,1,0,2);

    foreach (vecs[i]) begin
      reset = vecs[i].rs; req = vecs[i].rq; halt = vecs[i].h; br_en = vecs[i].b;
      br_idx = vecs[i].bi; lut_we = vecs[i].we; lut_waddr = vecs[i].wa; lut_wdata = vecs[i].wd;
      sb.push_back('{pc: vecs[i].pc, r: vecs[i].r, d: vecs[i].d, c: vecs[i].c});
      tick();
      e = sb.pop_front();
      chk($sformatf("v%0d prog_ctr", i), 32'(prog_ctr), 32'(e.pc));
      chk($sformatf("v%0d running", i), 32'(running), 32'(e.r));
      chk($sformatf("v%0d done", i), 32'(done), 32'(e.d));
      chk($sformatf("v%0d cycle_cnt", i), 32'(cycle_cnt), 32'(e.c));
    end

    // cycle counter saturation over a long run; prog_ctr wraps every 4096 cycles
    reset = 1; req = 0; halt = 0; br_en = 0; lut_we = 0;
    tick();
    reset = 0; req = 1;
    tick();
    req = 0;
    repeat (65534) tick();
    chk("sat cnt 65534", 32'(cycle_cnt), 32'd65534);
    chk("sat pc 65534", 32'(prog_ctr), 32'(65534 % 4096));
    tick();
    chk("sat cnt max", 32'(cycle_cnt), 32'd65535);
    tick();
    chk("sat cnt hold", 32'(cycle_cnt), 32'd65535);
    chk("sat pc wrap", 32'(prog_ctr), 32'd0);
    chk("sat running", 32'(running), 32'd1);
    halt = 1;
    tick();
    halt = 0;
    chk("sat halt done", 32'(done), 32'd1);
    chk("sat halt running", 32'(running), 32'd0);
    chk("sat halt cnt", 32'(cycle_cnt), 32'd65535);
    chk("sat halt pc", 32'(prog_ctr), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
